// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N_IN-input combinational block, samples f_in after a settle
// delay, and checks the captured truth table against an expected minterm mask.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_valid,
  output logic [1:0]             state_dbg
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Handshake: start is a request with no ready; it is taken only when state is IDLE,
  // and busy/done report progress. Requests in any other state are dropped, never queued.
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [NV-1:0]     tbl_q, tbl_d;
  logic [N_IN:0]     mcnt_q, mcnt_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              ffv_q, ffv_d;
  logic              match_q, match_d;
  logic              miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      vec_q   <= '0;
      tbl_q   <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      tbl_q   <= tbl_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    tbl_d   = tbl_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    match_d = match_q;
    miss    = f_in ^ exp_q[vec_q];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = expected;
          tbl_d   = '0;
          mcnt_d  = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          match_d = 1'b0;
          vec_d   = '0;
          cnt_d   = SETTLE_L;
          state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tbl_d[vec_q] = f_in;
        if (miss) begin
          mcnt_d = mcnt_q + CNT_ONE;
          if (!ffv_q) begin
            ff_d  = vec_q;
            ffv_d = 1'b1;
          end
        end
        // match is resolved on the last sample edge so it is already valid during DONE
        if (vec_q == LAST_VEC) begin
          state_d = S_DONE;
          match_d = (mcnt_d == '0);
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = SETTLE_L;
          state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done             = (state_q == S_DONE);
  assign table_out        = tbl_q;
  assign match            = match_q;
  assign mismatch_cnt     = mcnt_q;
  assign first_fail       = ff_q;
  assign first_fail_valid = ffv_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=1 and a SETTLE=0 instance driven by table-based
// function models, with expected sweep results queued at start and compared at done.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [15:0] expd  [2];
  logic [3:0]  vec   [2];
  logic        f     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [15:0] tbl_o [2];
  logic        match [2];
  logic [4:0]  cnt   [2];
  logic [3:0]  ff    [2];
  logic        ffv   [2];
  logic [1:0]  st    [2];
  logic [15:0] fn    [2];

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  // Function blocks under test are modelled as lookup tables on vec_out.
  assign f[0] = fn[0][vec[0]];
  assign f[1] = fn[1][vec[1]];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .expected(expd[0]), .vec_out(vec[0]),
    .f_in(f[0]), .busy(busy[0]), .done(done[0]), .table_out(tbl_o[0]), .match(match[0]),
    .mismatch_cnt(cnt[0]), .first_fail(ff[0]), .first_fail_valid(ffv[0]), .state_dbg(st[0])
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start[1]), .expected(expd[1]), .vec_out(vec[1]),
    .f_in(f[1]), .busy(busy[1]), .done(done[1]), .table_out(tbl_o[1]), .match(match[1]),
    .mismatch_cnt(cnt[1]), .first_fail(ff[1]), .first_fail_valid(ffv[1]), .state_dbg(st[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] model(input logic [15:0] ft, input logic [15:0] ex);
    logic [15:0] diff;
    logic [4:0]  c;
    logic [3:0]  first;
    logic        found;
    diff  = ft ^ ex;
    c     = '0;
    first = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (diff[k]) begin
        c = c + 5'd1;
        if (!found) begin
          first = 4'(k);
          found = 1'b1;
        end
      end
    end
    return {(diff == 16'h0), c, first, found, ft};
  endfunction

  function automatic logic [26:0] observed(input int i);
    return {match[i], cnt[i], ff[i], ffv[i], tbl_o[i]};
  endfunction

  function automatic logic [31:0] all_outs(input int i);
    return {3'b0, vec[i], busy[i], done[i], match[i], cnt[i], ff[i], ffv[i], st[i], 8'h0}
           | {16'h0, tbl_o[i]};
  endfunction

  // Start asserted in the first IDLE cycle; n counts edges from that assertion.
  task automatic sweep(input int i, input logic [15:0] ft, input logic [15:0] ex,
                       input bit disturb);
    int s;
    int n;
    bit got;
    logic [26:0] e;
    s = (i == 0) ? 1 : 0;
    fn[i] = ft;
    @(posedge clk); #1;
    expd[i]  = ex;
    start[i] = 1'b1;
    exp_q.push_back(model(ft, ex));
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start[i] = 1'b0;
        chk("clear_on_start", {tbl_o[i], cnt[i], ffv[i], match[i], busy[i], vec[i]},
            {16'h0, 5'h0, 1'b0, 1'b0, 1'b1, 4'h0});
      end
      if (disturb && n == 5) start[i] = 1'b1;
      if (disturb && n == 6) start[i] = 1'b0;
      if (disturb && n == 10) expd[i] = ~ex;
      if (done[i]) got = 1'b1;
      else if (n <= 16 * (s + 1))
        chk("vec_step", {busy[i], done[i], vec[i]}, {1'b1, 1'b0, 4'((n - 1) / (s + 1))});
    end
    chk("done_latency", n, 1 + 16 * (s + 1));
    chk("done_state", {busy[i], vec[i]}, {1'b0, 4'hF});
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("result", observed(i), e);
    end
  endtask

  initial begin
    int n;
    logic [15:0] rft, rex;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      expd[i]  = 16'h0;
      fn[i]    = 16'h0;
    end
    #12;
    chk("reset_s1", all_outs(0), 0);
    chk("reset_s0", all_outs(1), 0);
    @(negedge clk);
    rst = 1'b0;

    sweep(0, 16'h8000, 16'h8000, 1'b0);   // 4-input AND
    sweep(0, 16'h6996, 16'h6997, 1'b0);   // XOR vs wrong mask, single miss at vector 0
    sweep(0, 16'h8000, 16'h8000, 1'b0);   // back-to-back, clears prior mismatch
    sweep(1, 16'hFFFF, 16'hFFFF, 1'b0);   // SETTLE=0, constant 1
    sweep(1, 16'h00FF, 16'h0F0F, 1'b0);   // eight misses, first at 4
    sweep(1, 16'h0000, 16'hFFFF, 1'b0);   // every vector misses
    sweep(0, 16'h6996, 16'h6996, 1'b1);   // restart and expected change ignored

    // Asynchronous reset while vec_out == 7.
    fn[0] = 16'h8000;
    @(posedge clk); #1;
    expd[0]  = 16'h8000;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (vec[0] != 4'd7 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec7", vec[0], 4'd7);
    #2 rst = 1'b1;
    #1 chk("async_reset", all_outs(0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(0, 16'h6996, 16'h0000, 1'b0);

    rft = 16'($urandom_range(0, 65535));
    rex = 16'($urandom_range(0, 65535));
    sweep(0, rft, rex, 1'b0);
    sweep(1, rft, rex, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
